perf_counter_bank: RTL and testbench

Parametrised run-control and event-counter bank for the single-cycle MIPS core. It replaces the fixed three-counter block (all/branch/jump) with NUM_CH generic event counters and adds:
- a syscall halt / Go resume state machine that gates counting and drives the PC enable;
- sticky overflow flags with wrap or saturate mode;
- per-channel clear;
- a snapshot shadow bank;
- a registered read port for the LED/display mux.

Sits beside the PC register in the CPU top. The top ties channel 0 to 1'b1 (cycle count) and the other channels to branch-taken, jump and similar strobes.

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_counter_cell.sv | 45 ++++
 rtl/perf_counter_bank.sv | 91 +++++++++
 tb/tb_perf_counter_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance counter bank.
package perf_pkg;

  // Run-control states: counting is enabled only in ST_RUN.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // All-ones value of a w-bit counter (w up to 64), used as the overflow cap.
  function automatic logic [63:0] cap_value(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Width of the channel select; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with its sticky overflow flag and snapshot shadow.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             clr_ch,
  input  logic             snap,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] shadow,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CAP = WIDTH'(cap_value(WIDTH));

  // Counter, overflow and shadow update. The shadow samples the pre-edge
  // count, so a same-cycle increment or clear never leaks into it.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt    <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (snap) begin
        shadow <= cnt;
      end
      if (clr_ch) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (inc) begin
        if (cnt == CAP) begin
          ovf <= 1'b1;
          cnt <= (SATURATE != 0) ? CAP : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Run-control FSM (syscall halt / go resume) plus NUM_CH event counters
// with a registered read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0,
  parameter int SEL_W    = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              halt_i,
  input  logic              go,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [NUM_CH-1:0] clr_ch_i,
  input  logic              snap_i,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_shadow,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              run_o
);

  state_t           state_q;
  state_t           state_d;
  logic             go_q;
  logic             go_rise;
  logic [WIDTH-1:0] cnt_arr    [NUM_CH];
  logic [WIDTH-1:0] shadow_arr [NUM_CH];
  logic [WIDTH-1:0] sel_val;

  assign go_rise = go & ~go_q;
  // run_o decodes the state register only; halt_i has no direct path to it.
  assign run_o   = (state_q == ST_RUN);

  // State register and go edge-detect flop.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_RUN;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
    end
  end

  // Next state: halt beats a simultaneous go edge; halt_i is ignored in HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (halt_i)  state_d = ST_HALT;
      ST_HALT: if (go_rise) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // One counter cell per channel; events only count while running.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cell
    perf_counter_cell #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk    (clk),
      .clr    (clr),
      .inc    (event_i[g] & run_o),
      .clr_ch (clr_ch_i[g]),
      .snap   (snap_i),
      .cnt    (cnt_arr[g]),
      .shadow (shadow_arr[g]),
      .ovf    (ovf_o[g])
    );
  end

  // Read select; an out-of-range channel matches nothing and reads zero.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        sel_val = rd_shadow ? shadow_arr[i] : cnt_arr[i];
      end
    end
  end

  // Registered read port, one cycle behind the select.
  always_ff @(posedge clk) begin
    if (clr) rd_data <= '0;
    else     rd_data <= sel_val;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: main 32-bit bank, 4-bit wrap and
// saturate banks, and a 3-channel bank for the out-of-range select.
module tb_perf_counter_bank;

  logic        clk;
  logic        clr;
  logic        halt_i;
  logic        go;
  logic [3:0]  event_i;
  logic [3:0]  clr_ch_i;
  logic        snap_i;
  logic [1:0]  rd_sel;
  logic        rd_shadow;

  logic [31:0] rd_m;
  logic [3:0]  ovf_m;
  logic        run_m;
  logic [3:0]  rd_w;
  logic [3:0]  ovf_w;
  logic        run_w;
  logic [3:0]  rd_s;
  logic [3:0]  ovf_s;
  logic        run_s;
  logic [7:0]  rd_3;
  logic [2:0]  ovf_3;
  logic        run_3;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(4), .WIDTH(32), .SATURATE(0)) dut (
    .clk(clk), .clr(clr), .halt_i(halt_i), .go(go), .event_i(event_i),
    .clr_ch_i(clr_ch_i), .snap_i(snap_i), .rd_sel(rd_sel), .rd_shadow(rd_shadow),
    .rd_data(rd_m), .ovf_o(ovf_m), .run_o(run_m));

  perf_counter_bank #(.NUM_CH(4), .WIDTH(4), .SATURATE(0)) dut_w (
    .clk(clk), .clr(clr), .halt_i(halt_i), .go(go), .event_i(event_i),
    .clr_ch_i(clr_ch_i), .snap_i(snap_i), .rd_sel(rd_sel), .rd_shadow(rd_shadow),
    .rd_data(rd_w), .ovf_o(ovf_w), .run_o(run_w));

  perf_counter_bank #(.NUM_CH(4), .WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .clr(clr), .halt_i(halt_i), .go(go), .event_i(event_i),
    .clr_ch_i(clr_ch_i), .snap_i(snap_i), .rd_sel(rd_sel), .rd_shadow(rd_shadow),
    .rd_data(rd_s), .ovf_o(ovf_s), .run_o(run_s));

  perf_counter_bank #(.NUM_CH(3), .WIDTH(8), .SATURATE(0)) dut_3 (
    .clk(clk), .clr(clr), .halt_i(halt_i), .go(go), .event_i(event_i[2:0]),
    .clr_ch_i(clr_ch_i[2:0]), .snap_i(snap_i), .rd_sel(rd_sel), .rd_shadow(rd_shadow),
    .rd_data(rd_3), .ovf_o(ovf_3), .run_o(run_3));

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    halt_i = 0; go = 0; event_i = '0; clr_ch_i = '0; snap_i = 0;
    rd_sel = '0; rd_shadow = 0;
    clr = 1;
    step();
    clr = 0;
  endtask

  task automatic test_reset();
    event_i = 4'b1111;
    do_clr();
    n_tests++;
    if (run_m !== 1'b1) begin n_fail++; $display("FAIL reset_run: got %0b expected 1", run_m); end
    n_tests++;
    if (ovf_m !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0000", ovf_m); end
    n_tests++;
    if (rd_m !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", rd_m); end
  endtask

  task automatic test_free_run();
    do_clr();
    event_i = 4'b0001;
    step(10);
    event_i = 4'b0000;
    step();
    n_tests++;
    if (rd_m !== 32'd10) begin n_fail++; $display("FAIL free_run_count: got %0d expected 10", rd_m); end
    n_tests++;
    if (run_m !== 1'b1) begin n_fail++; $display("FAIL free_run_run: got %0b expected 1", run_m); end
    n_tests++;
    if (ovf_m !== 4'b0000) begin n_fail++; $display("FAIL free_run_ovf: got %b expected 0000", ovf_m); end
  endtask

  task automatic test_halt_resume();
    do_clr();
    event_i = 4'b0001;
    go = 1;
    step(5);
    halt_i = 1;
    step();
    halt_i = 0;
    n_tests++;
    if (run_m !== 1'b0) begin n_fail++; $display("FAIL halt_enter: run got %0b expected 0", run_m); end
    step(3);
    n_tests++;
    if (rd_m !== 32'd6) begin n_fail++; $display("FAIL halt_frozen: got %0d expected 6", rd_m); end
    n_tests++;
    if (run_m !== 1'b0) begin n_fail++; $display("FAIL halt_go_level: run got %0b expected 0", run_m); end
    go = 0;
    step();
    go = 1;
    step();
    n_tests++;
    if (run_m !== 1'b1) begin n_fail++; $display("FAIL resume_run: got %0b expected 1", run_m); end
    step(2);
    event_i = 4'b0000;
    go = 0;
    step();
    n_tests++;
    if (rd_m !== 32'd8) begin n_fail++; $display("FAIL resume_count: got %0d expected 8", rd_m); end
  endtask

  task automatic test_overflow_wrap();
    do_clr();
    rd_sel = 2'd1;
    event_i = 4'b0010;
    step(17);
    event_i = 4'b0000;
    step();
    n_tests++;
    if (rd_w !== 4'd1) begin n_fail++; $display("FAIL wrap_count: got %0d expected 1", rd_w); end
    n_tests++;
    if (ovf_w !== 4'b0010) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0010", ovf_w); end
    step(2);
    n_tests++;
    if (ovf_w !== 4'b0010) begin n_fail++; $display("FAIL wrap_ovf_sticky: got %b expected 0010", ovf_w); end
    clr_ch_i = 4'b0010;
    step();
    clr_ch_i = 4'b0000;
    step();
    n_tests++;
    if (rd_w !== 4'd0) begin n_fail++; $display("FAIL clr_ch_count: got %0d expected 0", rd_w); end
    n_tests++;
    if (ovf_w !== 4'b0000) begin n_fail++; $display("FAIL clr_ch_ovf: got %b expected 0000", ovf_w); end
  endtask

  task automatic test_saturate();
    do_clr();
    rd_sel = 2'd2;
    event_i = 4'b0100;
    step(20);
    event_i = 4'b0000;
    step();
    n_tests++;
    if (rd_s !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d expected 15", rd_s); end
    n_tests++;
    if (ovf_s !== 4'b0100) begin n_fail++; $display("FAIL sat_ovf: got %b expected 0100", ovf_s); end
    n_tests++;
    if (rd_w !== 4'd4) begin n_fail++; $display("FAIL wrap20_count: got %0d expected 4", rd_w); end
  endtask

  task automatic test_snap_race();
    do_clr();
    rd_sel = 2'd3;
    event_i = 4'b1000;
    step(7);
    snap_i = 1;
    clr_ch_i = 4'b1000;
    step();
    snap_i = 0;
    clr_ch_i = 4'b0000;
    event_i = 4'b0000;
    step();
    n_tests++;
    if (rd_m !== 32'd0) begin n_fail++; $display("FAIL race_live: got %0d expected 0", rd_m); end
    rd_shadow = 1;
    step();
    n_tests++;
    if (rd_m !== 32'd7) begin n_fail++; $display("FAIL race_shadow: got %0d expected 7", rd_m); end
    rd_shadow = 0;
  endtask

  task automatic test_out_of_range();
    do_clr();
    event_i = 4'b1111;
    step(3);
    event_i = 4'b0000;
    rd_sel = 2'd2;
    step();
    n_tests++;
    if (rd_3 !== 8'd3) begin n_fail++; $display("FAIL sel_in_range: got %0d expected 3", rd_3); end
    rd_sel = 2'd3;
    step();
    n_tests++;
    if (rd_3 !== 8'd0) begin n_fail++; $display("FAIL sel_out_of_range: got %0d expected 0", rd_3); end
    n_tests++;
    if (rd_m !== 32'd3) begin n_fail++; $display("FAIL sel_ch3_main: got %0d expected 3", rd_m); end
  endtask

  task automatic test_halt_go_race();
    do_clr();
    step();
    halt_i = 1;
    go = 1;
    step();
    halt_i = 0;
    n_tests++;
    if (run_3 !== 1'b0) begin n_fail++; $display("FAIL race_halt_wins: run got %0b expected 0", run_3); end
    step();
    n_tests++;
    if (run_3 !== 1'b0) begin n_fail++; $display("FAIL race_go_held: run got %0b expected 0", run_3); end
    go = 0;
    step();
    go = 1;
    step();
    go = 0;
    n_tests++;
    if (run_3 !== 1'b1) begin n_fail++; $display("FAIL race_resume: run got %0b expected 1", run_3); end
  endtask

  task automatic test_clr_from_halt();
    do_clr();
    rd_sel = 2'd0;
    event_i = 4'b0001;
    step(4);
    halt_i = 1;
    step();
    halt_i = 0;
    n_tests++;
    if (run_m !== 1'b0) begin n_fail++; $display("FAIL clr_halt_enter: run got %0b expected 0", run_m); end
    clr = 1;
    step();
    clr = 0;
    event_i = 4'b0000;
    n_tests++;
    if (run_m !== 1'b1) begin n_fail++; $display("FAIL clr_halt_run: got %0b expected 1", run_m); end
    step();
    n_tests++;
    if (rd_m !== 32'd0) begin n_fail++; $display("FAIL clr_halt_count: got %0d expected 0", rd_m); end
  endtask

  initial begin
    clr = 1; halt_i = 0; go = 0; event_i = '0; clr_ch_i = '0;
    snap_i = 0; rd_sel = '0; rd_shadow = 0;
    step(2);
    test_reset();
    test_free_run();
    test_halt_resume();
    test_overflow_wrap();
    test_saturate();
    test_snap_race();
    test_out_of_range();
    test_halt_go_race();
    test_clr_from_halt();
    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
